// File: rtl/ham_pkg.sv
// ============================================================================
// Module   : ham_pkg
// Brief    : Shared mode constants and FSM state encoding for hamming_unit_iter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ham_pkg;

    localparam logic HAM_MODE_WEIGHT = 1'b0;
    localparam logic HAM_MODE_DIST   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ham_state_e;

endpackage

`default_nettype wire

// File: rtl/hamming_unit_iter_if.sv
// ============================================================================
// Module   : hamming_unit_iter_if
// Brief    : Request/result valid-ready bundle of the iterative Hamming unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hamming_unit_iter_if #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] weight;
    logic             busy;

    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, weight, busy
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, weight, busy
    );
endinterface

`default_nettype wire

// File: rtl/hamming_unit_iter_chunk_popcount.sv
// ============================================================================
// Module   : chunk_popcount
// Brief    : Combinational set-bit count of one CHUNK-bit slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_popcount #(
    parameter int CHUNK = 8
) (
    input  wire logic [CHUNK-1:0]             data,
    output logic      [$clog2(CHUNK+1)-1:0]   count
);
    localparam int PC_W = $clog2(CHUNK + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PC_W'(data[i]);
        end
    end
endmodule

`default_nettype wire

// File: rtl/hamming_unit_iter.sv
// ============================================================================
// Module   : hamming_unit_iter
// Brief    : Multi-cycle Hamming weight/distance unit, CHUNK bits per cycle.
//            Optional HAM_EARLY_EXIT_EN finishes once the remaining bits are 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_unit_iter
    import ham_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int OUT_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    hamming_unit_iter_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int ACC_W  = $clog2(WIDTH + 1);
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    ham_state_e       r_state;
    ham_state_e       w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] w_x_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [PC_W-1:0]  w_pc;
    logic             w_last;
    logic [OUT_W-1:0] r_weight;
    logic             r_out_valid;

    chunk_popcount #(.CHUNK(CHUNK)) u_pc (
        .data  (r_x[CHUNK-1:0]),
        .count (w_pc)
    );

    assign w_sum = r_acc + ACC_W'(w_pc);

    if (WIDTH > CHUNK) begin : g_shift
        assign w_x_shift = {{CHUNK{1'b0}}, r_x[WIDTH-1:CHUNK]};
    end else begin : g_no_shift
        assign w_x_shift = '0;
    end

`ifdef HAM_EARLY_EXIT_EN
    // Nothing left to count once the shifted operand is all zeros.
    assign w_last = (r_cnt == CNT_W'(NCHUNK - 1)) || (w_x_shift == '0);
`else
    assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)        w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_weight    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_x   <= (bus.in_mode == HAM_MODE_DIST) ? (bus.in_a ^ bus.in_b) : bus.in_a;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_x   <= w_x_shift;
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_weight    <= OUT_W'(w_sum);
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.weight    = r_weight;

endmodule

`default_nettype wire
